// File: rtl/branch_resolve_unit_if.sv
// Resolve request and registered result bundle between the execute stage and
// the branch resolve unit; the stage drives requests, the unit answers one cycle later.
interface branch_resolve_unit_if #(
   parameter int XLEN = 32
);
   logic            res_valid;
   logic [5:0]      res_sel;
   logic [XLEN-1:0] res_pc;
   logic [XLEN-1:0] res_target;
   logic [XLEN-1:0] rs1;
   logic [XLEN-1:0] rs2;
   logic            res_pred_taken;
   logic            flush;

   logic            out_valid;
   logic            out_taken;
   logic            out_mispredict;
   logic [XLEN-1:0] out_redirect_pc;

   modport master (
      output res_valid, res_sel, res_pc, res_target, rs1, rs2, res_pred_taken, flush,
      input  out_valid, out_taken, out_mispredict, out_redirect_pc
   );

   modport slave (
      input  res_valid, res_sel, res_pc, res_target, rs1, rs2, res_pred_taken, flush,
      output out_valid, out_taken, out_mispredict, out_redirect_pc
   );
endinterface

// File: rtl/branch_resolve_unit.sv
// Branch resolution stage: evaluates branches/jumps, trains a 2-bit counter BHT
// read by fetch, and reports mispredictions, redirect PC and saturating statistics.
module branch_resolve_unit #(
   parameter int XLEN        = 32,
   parameter int BHT_ENTRIES = 16,
   parameter int CNT_W       = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [XLEN-1:0]       lookup_pc,
   output logic                  predict_taken,
   branch_resolve_unit_if.slave  res,
   output logic [CNT_W-1:0]      branch_count,
   output logic [CNT_W-1:0]      mispredict_count
);

   localparam int IDX_W = $clog2(BHT_ENTRIES);

   localparam logic [5:0] SEL_JAL  = 6'b000011;
   localparam logic [5:0] SEL_JALR = 6'b000100;
   localparam logic [5:0] SEL_BEQ  = 6'b000101;
   localparam logic [5:0] SEL_BNE  = 6'b000110;
   localparam logic [5:0] SEL_BLT  = 6'b000111;
   localparam logic [5:0] SEL_BGE  = 6'b001000;
   localparam logic [5:0] SEL_BLTU = 6'b001001;
   localparam logic [5:0] SEL_BGEU = 6'b001010;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [1:0]      bht [BHT_ENTRIES];
   logic [IDX_W-1:0] lookup_idx;
   logic [IDX_W-1:0] update_idx;
   logic            is_branch;
   logic            is_jump;
   logic            taken;
   logic            mispredict;
   logic            accept;
   logic [XLEN-1:0] redirect_pc;
   logic            unused_lookup_bits;

   assign lookup_idx         = lookup_pc[IDX_W+1:2];
   assign update_idx         = res.res_pc[IDX_W+1:2];
   assign predict_taken      = bht[lookup_idx][1];
   assign unused_lookup_bits = ^{lookup_pc[1:0], lookup_pc >> (IDX_W + 2)};

   // Decode the select and evaluate the branch condition for the current request.
   always_comb begin
      is_branch = 1'b0;
      is_jump   = 1'b0;
      taken     = 1'b0;
      case (res.res_sel)
         SEL_BEQ:  begin is_branch = 1'b1; taken = (res.rs1 == res.rs2); end
         SEL_BNE:  begin is_branch = 1'b1; taken = (res.rs1 != res.rs2); end
         SEL_BLT:  begin is_branch = 1'b1; taken = ($signed(res.rs1) <  $signed(res.rs2)); end
         SEL_BGE:  begin is_branch = 1'b1; taken = ($signed(res.rs1) >= $signed(res.rs2)); end
         SEL_BLTU: begin is_branch = 1'b1; taken = (res.rs1 <  res.rs2); end
         SEL_BGEU: begin is_branch = 1'b1; taken = (res.rs1 >= res.rs2); end
         SEL_JAL,
         SEL_JALR: begin is_jump = 1'b1; taken = 1'b1; end
         default:  taken = 1'b0;
      endcase
      mispredict  = taken ^ res.res_pred_taken;
      accept      = res.res_valid & ~res.flush;
      redirect_pc = taken ? res.res_target : (res.res_pc + XLEN'(4));
   end

   // BHT training; lookups see the old value because the write lands at the edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < BHT_ENTRIES; i++) begin
            bht[i] <= 2'b01;
         end
      end else if (accept && is_branch) begin
         if (taken && (bht[update_idx] != 2'b11)) begin
            bht[update_idx] <= bht[update_idx] + 2'd1;
         end else if (!taken && (bht[update_idx] != 2'b00)) begin
            bht[update_idx] <= bht[update_idx] - 2'd1;
         end
      end
   end

   // Result registers hold their last value between accepted requests.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         res.out_valid       <= 1'b0;
         res.out_taken       <= 1'b0;
         res.out_mispredict  <= 1'b0;
         res.out_redirect_pc <= '0;
      end else begin
         res.out_valid <= accept;
         if (accept) begin
            res.out_taken       <= taken;
            res.out_mispredict  <= mispredict;
            res.out_redirect_pc <= redirect_pc;
         end
      end
   end

   // Statistics: unknown selects never count, jumps only count as mispredicts.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         branch_count     <= '0;
         mispredict_count <= '0;
      end else if (accept) begin
         if (is_branch && (branch_count != CNT_MAX)) begin
            branch_count <= branch_count + CNT_W'(1);
         end
         if ((is_branch || is_jump) && mispredict && (mispredict_count != CNT_MAX)) begin
            mispredict_count <= mispredict_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed vector table, hand sequences
// for BHT training, flush and reset, plus random traffic against a behavioural model.
module tb_branch_resolve_unit;

   localparam logic [5:0] S_JAL  = 6'd3;
   localparam logic [5:0] S_JALR = 6'd4;
   localparam logic [5:0] S_BEQ  = 6'd5;
   localparam logic [5:0] S_BNE  = 6'd6;
   localparam logic [5:0] S_BLT  = 6'd7;
   localparam logic [5:0] S_BGE  = 6'd8;
   localparam logic [5:0] S_BLTU = 6'd9;
   localparam logic [5:0] S_BGEU = 6'd10;

   logic        clk;
   logic        reset_n;
   logic        reset_n_s;
   logic [31:0] lookup_pc;
   logic [31:0] lookup_pc_s;
   logic        predict_taken;
   logic        predict_taken_s;
   logic [15:0] branch_count;
   logic [15:0] mispredict_count;
   logic [3:0]  branch_count_s;
   logic [3:0]  mispredict_count_s;

   branch_resolve_unit_if #(.XLEN(32)) bus ();
   branch_resolve_unit_if #(.XLEN(32)) bus_s ();

   branch_resolve_unit #(.XLEN(32), .BHT_ENTRIES(16), .CNT_W(16)) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .lookup_pc        (lookup_pc),
      .predict_taken    (predict_taken),
      .res              (bus.slave),
      .branch_count     (branch_count),
      .mispredict_count (mispredict_count)
   );

   branch_resolve_unit #(.XLEN(32), .BHT_ENTRIES(4), .CNT_W(4)) dut_s (
      .clk              (clk),
      .reset_n          (reset_n_s),
      .lookup_pc        (lookup_pc_s),
      .predict_taken    (predict_taken_s),
      .res              (bus_s.slave),
      .branch_count     (branch_count_s),
      .mispredict_count (mispredict_count_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [5:0]  sel;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] pc;
      logic [31:0] tgt;
      logic        pred;
      logic        exp_taken;
      logic        exp_mis;
      logic [31:0] exp_redirect;
   } vec_t;

   vec_t vecs [10];

   int pass_cnt  = 0;
   int total_cnt = 0;

   // Behavioural reference state
   int          bht_m [16];
   int          bcnt_m;
   int          mcnt_m;
   logic        last_taken;
   logic        last_mis;
   logic [31:0] last_red;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   function automatic logic model_taken(input logic [5:0] sel, input logic [31:0] a, input logic [31:0] b);
      case (sel)
         S_BEQ:          return a == b;
         S_BNE:          return a != b;
         S_BLT:          return $signed(a) <  $signed(b);
         S_BGE:          return $signed(a) >= $signed(b);
         S_BLTU:         return a <  b;
         S_BGEU:         return a >= b;
         S_JAL, S_JALR:  return 1'b1;
         default:        return 1'b0;
      endcase
   endfunction

   function automatic logic model_predict(input logic [31:0] pc);
      return bht_m[(pc / 4) % 16] >= 2;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) bht_m[i] = 1;
      bcnt_m     = 0;
      mcnt_m     = 0;
      last_taken = 1'b0;
      last_mis   = 1'b0;
      last_red   = 32'h0;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_valid"},    {31'b0, bus.out_valid}, 32'h0);
      check({tag, "_taken"},    {31'b0, bus.out_taken}, 32'h0);
      check({tag, "_mis"},      {31'b0, bus.out_mispredict}, 32'h0);
      check({tag, "_redirect"}, bus.out_redirect_pc, 32'h0);
      check({tag, "_bcnt"},     {16'b0, branch_count}, 32'h0);
      check({tag, "_mcnt"},     {16'b0, mispredict_count}, 32'h0);
   endtask

   // Asserts reset mid-cycle (asynchronous), checks outputs clear at once, releases at a negedge.
   task automatic reset_dut(input string tag);
      #2;
      reset_n = 1'b0;
      #1;
      check_reset_state(tag);
      model_reset();
      bus.res_valid = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   // Called at a negedge: drives one request, checks prediction before and results after the edge.
   task automatic apply_stimulus(input string name, input logic valid, input logic [5:0] sel,
                                 input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc,
                                 input logic [31:0] tgt, input logic pred, input logic fl,
                                 input logic [31:0] look);
      logic t;
      logic accepted;
      int   idx;
      bus.res_valid      = valid;
      bus.res_sel        = sel;
      bus.rs1            = a;
      bus.rs2            = b;
      bus.res_pc         = pc;
      bus.res_target     = tgt;
      bus.res_pred_taken = pred;
      bus.flush          = fl;
      lookup_pc          = look;
      #1;
      check({name, "_pred_before"}, {31'b0, predict_taken}, {31'b0, model_predict(look)});
      t        = model_taken(sel, a, b);
      accepted = valid && !fl;
      if (accepted) begin
         idx        = (pc / 4) % 16;
         last_taken = t;
         last_mis   = t ^ pred;
         last_red   = t ? tgt : pc + 32'd4;
         if (sel >= S_BEQ && sel <= S_BGEU) begin
            bht_m[idx] = t ? ((bht_m[idx] < 3) ? bht_m[idx] + 1 : 3)
                           : ((bht_m[idx] > 0) ? bht_m[idx] - 1 : 0);
            if (bcnt_m < 65535) bcnt_m++;
         end
         if ((sel >= S_JAL && sel <= S_BGEU) && (t ^ pred) && mcnt_m < 65535) mcnt_m++;
      end
      @(negedge clk);
      check_output(name, accepted, look);
      bus.res_valid = 1'b0;
   endtask

   task automatic check_output(input string name, input logic accepted, input logic [31:0] look);
      check({name, "_valid"},      {31'b0, bus.out_valid}, {31'b0, accepted});
      check({name, "_taken"},      {31'b0, bus.out_taken}, {31'b0, last_taken});
      check({name, "_mis"},        {31'b0, bus.out_mispredict}, {31'b0, last_mis});
      check({name, "_redirect"},   bus.out_redirect_pc, last_red);
      check({name, "_bcnt"},       {16'b0, branch_count}, bcnt_m);
      check({name, "_mcnt"},       {16'b0, mispredict_count}, mcnt_m);
      check({name, "_pred_after"}, {31'b0, predict_taken}, {31'b0, model_predict(look)});
   endtask

   initial begin
      logic [5:0]  sel_list [10];
      logic [5:0]  rs;
      logic [31:0] ra;
      logic [31:0] rb;
      logic [31:0] rpc;

      vecs[0] = '{S_BLT,  32'hFFFFFFFF, 32'h1, 32'h100, 32'h80,   1'b0, 1'b1, 1'b1, 32'h80};
      vecs[1] = '{S_BLTU, 32'hFFFFFFFF, 32'h1, 32'h200, 32'h300,  1'b0, 1'b0, 1'b0, 32'h204};
      vecs[2] = '{S_BGEU, 32'hFFFFFFFF, 32'h1, 32'h204, 32'h400,  1'b0, 1'b1, 1'b1, 32'h400};
      vecs[3] = '{S_BEQ,  32'h5,        32'h5, 32'h208, 32'h500,  1'b1, 1'b1, 1'b0, 32'h500};
      vecs[4] = '{S_BNE,  32'h5,        32'h5, 32'h20C, 32'h600,  1'b1, 1'b0, 1'b1, 32'h210};
      vecs[5] = '{S_BGE,  32'hFFFFFFFF, 32'h1, 32'h210, 32'h700,  1'b1, 1'b0, 1'b1, 32'h214};
      vecs[6] = '{S_JAL,  32'h0,        32'h0, 32'h300, 32'h1000, 1'b0, 1'b1, 1'b1, 32'h1000};
      vecs[7] = '{S_JALR, 32'h0,        32'h0, 32'h304, 32'h2000, 1'b1, 1'b1, 1'b0, 32'h2000};
      vecs[8] = '{6'd0,   32'h7,        32'h7, 32'h308, 32'h3000, 1'b0, 1'b0, 1'b0, 32'h30C};
      vecs[9] = '{S_BEQ,  32'h1,        32'h2, 32'hFFFFFFFC, 32'h10, 1'b0, 1'b0, 1'b0, 32'h0};

      sel_list = '{S_JAL, S_JALR, S_BEQ, S_BNE, S_BLT, S_BGE, S_BLTU, S_BGEU, 6'd0, 6'd63};

      bus.res_valid = 1'b0;   bus.res_sel = '0;  bus.res_pc = '0;  bus.res_target = '0;
      bus.rs1 = '0;           bus.rs2 = '0;      bus.res_pred_taken = 1'b0;  bus.flush = 1'b0;
      bus_s.res_valid = 1'b0; bus_s.res_sel = '0; bus_s.res_pc = '0; bus_s.res_target = '0;
      bus_s.rs1 = '0;         bus_s.rs2 = '0;    bus_s.res_pred_taken = 1'b0; bus_s.flush = 1'b0;
      lookup_pc   = 32'h100;
      lookup_pc_s = 32'h0;
      reset_n     = 1'b0;
      reset_n_s   = 1'b0;
      model_reset();
      #12;
      check_reset_state("reset");
      check("reset_predict", {31'b0, predict_taken}, 32'h0);
      @(negedge clk);
      reset_n   = 1'b1;
      reset_n_s = 1'b1;

      // Directed vectors, back to back
      for (int i = 0; i < 10; i++) begin
         apply_stimulus($sformatf("vec%0d", i), 1'b1, vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].pc,
                        vecs[i].tgt, vecs[i].pred, 1'b0, vecs[i].pc);
         check($sformatf("vec%0d_tbl_taken", i), {31'b0, bus.out_taken}, {31'b0, vecs[i].exp_taken});
         check($sformatf("vec%0d_tbl_mis", i), {31'b0, bus.out_mispredict}, {31'b0, vecs[i].exp_mis});
         check($sformatf("vec%0d_tbl_redirect", i), bus.out_redirect_pc, vecs[i].exp_redirect);
      end
      check("vec_bcnt_total", {16'b0, branch_count}, 32'd7);
      check("vec_mcnt_total", {16'b0, mispredict_count}, 32'd5);

      // Flush suppresses result, counters and training; idle cycle afterwards
      apply_stimulus("flush", 1'b1, S_BEQ, 32'h3, 32'h3, 32'h40, 32'h900, 1'b0, 1'b1, 32'h40);
      apply_stimulus("idle", 1'b0, S_BEQ, 32'h3, 32'h3, 32'h40, 32'h900, 1'b0, 1'b0, 32'h40);

      // Reset while a result is pending, then BHT training at pc 0x40
      apply_stimulus("pend", 1'b1, S_BEQ, 32'h1, 32'h1, 32'h44, 32'h900, 1'b0, 1'b0, 32'h44);
      reset_dut("midreset");
      for (int i = 0; i < 3; i++) begin
         apply_stimulus($sformatf("train%0d", i), 1'b1, S_BEQ, 32'h9, 32'h9, 32'h40, 32'h800,
                        1'b0, 1'b0, 32'h40);
      end
      check("train_sat_pred", {31'b0, predict_taken}, 32'h1);
      apply_stimulus("untrain", 1'b1, S_BEQ, 32'h9, 32'h8, 32'h40, 32'h800, 1'b1, 1'b0, 32'h40);
      check("untrain_pred", {31'b0, predict_taken}, 32'h1);
      apply_stimulus("untrain2", 1'b1, S_BEQ, 32'h9, 32'h8, 32'h40, 32'h800, 1'b1, 1'b0, 32'h40);
      check("untrain2_pred", {31'b0, predict_taken}, 32'h0);
      apply_stimulus("jal_bht", 1'b1, S_JAL, 32'h0, 32'h0, 32'h40, 32'h700, 1'b0, 1'b0, 32'h40);

      // Random traffic against the model
      for (int i = 0; i < 300; i++) begin
         rs  = sel_list[$urandom_range(0, 9)];
         ra  = $urandom;
         rb  = ($urandom_range(0, 3) == 0) ? ra : $urandom;
         rpc = 32'h1000 + 32'($urandom_range(0, 31)) * 4;
         apply_stimulus($sformatf("rnd%0d", i), ($urandom_range(0, 5) != 0), rs, ra, rb, rpc,
                        $urandom & 32'hFFFFFFFC, 1'($urandom_range(0, 1)),
                        ($urandom_range(0, 7) == 0),
                        ($urandom_range(0, 1) == 0) ? rpc : 32'h1000 + 32'($urandom_range(0, 31)) * 4);
      end

      // Small instance: counters saturate at 0xF
      for (int n = 1; n <= 20; n++) begin
         bus_s.res_valid = 1'b1; bus_s.res_sel = S_BEQ; bus_s.rs1 = 32'h2; bus_s.rs2 = 32'h2;
         bus_s.res_pc = 32'h0;   bus_s.res_target = 32'h40; bus_s.res_pred_taken = 1'b0;
         @(negedge clk);
         check($sformatf("sat_bcnt%0d", n), {28'b0, branch_count_s}, (n > 15) ? 32'd15 : 32'(n));
         check($sformatf("sat_mcnt%0d", n), {28'b0, mispredict_count_s}, (n > 15) ? 32'd15 : 32'(n));
      end
      check("sat_valid", {31'b0, bus_s.out_valid}, 32'h1);
      check("sat_pred", {31'b0, predict_taken_s}, 32'h1);
      #2;
      reset_n_s = 1'b0;
      #1;
      check("s_reset_valid", {31'b0, bus_s.out_valid}, 32'h0);
      check("s_reset_taken", {31'b0, bus_s.out_taken}, 32'h0);
      check("s_reset_mis", {31'b0, bus_s.out_mispredict}, 32'h0);
      check("s_reset_redirect", bus_s.out_redirect_pc, 32'h0);
      check("s_reset_bcnt", {28'b0, branch_count_s}, 32'h0);
      check("s_reset_mcnt", {28'b0, mispredict_count_s}, 32'h0);
      check("s_reset_pred", {31'b0, predict_taken_s}, 32'h0);
      @(negedge clk);
      check("s_reset_hold_valid", {31'b0, bus_s.out_valid}, 32'h0);
      bus_s.res_valid = 1'b0;
      reset_n_s       = 1'b1;
      @(negedge clk);
      check("s_idle_valid", {31'b0, bus_s.out_valid}, 32'h0);
      // One taken branch moves a freshly reset 01 entry to 10
      bus_s.res_valid = 1'b1;
      @(negedge clk);
      bus_s.res_valid = 1'b0;
      check("s_retrain_pred", {31'b0, predict_taken_s}, 32'h1);
      check("s_retrain_bcnt", {28'b0, branch_count_s}, 32'h1);
      lookup_pc_s = 32'h4;
      #1;
      check("s_other_entry_pred", {31'b0, predict_taken_s}, 32'h0);

      $display("[TB] %0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Parametrised branch resolution stage for the RV32 pipeline. It evaluates conditional branches and jumps using the team's 6-bit aluSelect encodings, and keeps a BHT of 2-bit saturating counters that fetch reads each cycle. It also flags mispredictions, produces the redirect PC one cycle after resolution, and maintains saturating branch/mispredict statistics counters.

## Interface
Parameters:
- XLEN, 32, operand and PC width
- BHT_ENTRIES, 16, number of 2-bit counters; power of two, ≥2
- CNT_W, 16, width of the statistics counters

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- lookup_pc  input  XLEN  fetch PC for prediction
- predict_taken  output  1  combinational; MSB of BHT[lookup_pc index]
- res_valid  input  1  resolve request this cycle
- res_sel  input  6  aluSelect: BEQ 000101, BNE 000110, BLT 000111, BGE 001000, BLTU 001001, BGEU 001010, JAL 000011, JALR 000100
- res_pc  input  XLEN  PC of the resolving instruction
- res_target  input  XLEN  precomputed taken target
- rs1, rs2  input  XLEN  compare operands
- res_pred_taken  input  1  prediction fetch used for this instruction
- flush  input  1  kill the result being registered this cycle
- out_valid  output  1  registered result valid
- out_taken  output  1  registered actual outcome
- out_mispredict  output  1  registered; actual ≠ predicted
- out_redirect_pc  output  XLEN  res_target if taken, else res_pc+4 (mod 2^XLEN)
- branch_count  output  CNT_W  resolved conditional branches
- mispredict_count  output  CNT_W  mispredicted conditional branches and jumps

## Operation
- Index = res_pc[log2(BHT_ENTRIES)+1:2] for updates and lookup_pc[same bits] for lookup. PC bits [1:0] are ignored.
- Compare rules (combinational on accepted request):
  - Signed compares for BLT and BGE.
  - Unsigned compares for BLTU and BGEU.
  - JAL and JALR are always taken.
  - Any other res_sel is not taken. It still produces out_valid and a redirect of res_pc+4, and is counted nowhere.
- mispredict = taken XOR res_pred_taken. This applies to jumps as well (a predicted not-taken jump mispredicts).
- BHT update happens only for conditional branches with res_valid=1 and flush=0:
  - Taken: counter +1, saturating at 11.
  - Not taken: counter −1, saturating at 00.
- Jumps and unknown selects never touch the BHT.
- branch_count increments per accepted conditional branch and saturates at all-ones.
- mispredict_count increments per accepted mispredicting branch or jump and saturates at all-ones.
- flush=1 in the same cycle as res_valid suppresses everything: no out_valid, no BHT update, no counter change.

## Timing
- Reset (async assert, sync-safe deassert):
  - out_valid=0, out_taken=0, out_mispredict=0, out_redirect_pc=0.
  - Counters = 0.
  - Every BHT entry = 01 (weakly not taken), so predict_taken=0.
  - Reset mid-operation discards any pending result.
- Latency: request sampled at edge N produces outputs valid after edge N (one cycle). out_valid is a 1-cycle pulse per request. Back-to-back requests give back-to-back pulses. There is no backpressure.
- When res_valid=0 (or flush=1), out_valid=0 next cycle. The other out_* registers hold their last values.
- Same-cycle lookup and update of the same index: predict_taken reflects the pre-update value (read-before-write). The new value is visible the following cycle.
- Counters update at the same edge as out_valid.

## Test plan
- Reset, then lookup_pc=0x100 → predict_taken=0. BLT with rs1=0xFFFFFFFF, rs2=1, pred=0, pc=0x100, target=0x80 → next cycle out_taken=1, out_mispredict=1, out_redirect_pc=0x80, branch_count=1, mispredict_count=1.
- BLTU with the same operands, pc=0x200 → out_taken=0, redirect=0x204. BGEU → taken. BEQ/BNE with equal operands → 1/0.
- Three taken BEQs at pc=0x40:
  - BHT[index 0] goes 01→10→11→11.
  - predict_taken at lookup_pc=0x40 reads 0,1,1,1 across the cycles, including old-value reads on the update cycles.
  - Then one not-taken BEQ → 10, predict still 1.
- JAL with pred=0 → out_taken=1, mispredict=1, BHT unchanged, branch_count unchanged, mispredict_count+1. JALR with pred=1 → no mispredict.
- res_valid with flush=1 → out_valid=0, counters and BHT unchanged. res_pc=0xFFFFFFFC, not taken → redirect=0x00000000.
- With CNT_W=4 (BHT_ENTRIES=4), issue 20 mispredicting branches → both counters stick at 0xF. Assert reset_n mid-stream → all outputs and counters are 0 immediately, BHT entries are 01, and the pending out_valid is lost.
